// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 non-restoring, one quotient bit per clock.
// Companion to the radix-2 Booth multiplier; start/done handshake, truncating division.
module booth_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] R,
    output logic                  dbz,
    output logic                  ovf
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [2*N:0]  pa;      // {P, A}: partial remainder over dividend/quotient shift register
    logic [N:0]    b;
    logic          xneg, qneg, yzero;

    logic [N:0]    x_abs, y_abs, p, p_sh, p_nx;
    logic [N-1:0]  a, r_mag;

    always_comb begin
        x_abs = x[N-1] ? -{1'b1, x} : {1'b0, x};
        y_abs = y[N-1] ? -{1'b1, y} : {1'b0, y};
        p     = pa[2*N:N];
        a     = pa[N-1:0];
        p_sh  = pa[2*N-1:N-1];
        p_nx  = p[N] ? p_sh + b : p_sh - b;
        r_mag = N'(p[N] ? p + b : p);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            pa      <= '0;
            b       <= '0;
            xneg    <= 1'b0;
            qneg    <= 1'b0;
            yzero   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Q       <= '0;
            R       <= '0;
            dbz     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pa    <= {{N{1'b0}}, x_abs};
                    b     <= y_abs;
                    xneg  <= x[N-1];
                    qneg  <= x[N-1] ^ y[N-1];
                    yzero <= (y == '0);
                    busy  <= 1'b1;
                    if (y == '0) begin
                        state   <= FIX;
                        counter <= CW'(1);
                    end else begin
                        state   <= CALC;
                        counter <= CW'(N);
                    end
                end
                CALC: begin
                    pa <= {p_nx, pa[N-2:0], ~p_nx[N]};
                    // counter parks at 1 through FIX so it reads 0 only in IDLE
                    if (counter == CW'(1)) state <= FIX;
                    else                   counter <= counter - CW'(1);
                end
                FIX: begin
                    Q   <= yzero ? '1 : (qneg ? -a : a);
                    R   <= yzero ? (xneg ? -a : a) : (xneg ? -r_mag : r_mag);
                    dbz <= yzero;
                    // a positive quotient of magnitude 2^(N-1) only arises from MIN / -1
                    ovf <= !yzero && !qneg && a[N-1];
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: directed vector table, handshake/reset sequences,
// and back-to-back random operands checked against plain signed arithmetic.
module tb_booth_divider;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [N-1:0] x, y, Q, R;
    logic         busy, done, dbz, ovf;

    booth_divider #(.DATA_WIDTH(N)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] x, y, q, r;
        logic         z, o;
        int           lat;
    } vec_t;

    vec_t         vecs[10];
    int           pass_cnt = 0;
    int           chk_cnt  = 0;
    logic [N-1:0] rx[100], ry[100];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic setv(input int i, input int xx, input int yy, input int q, input int r,
                        input int z, input int o, input int lat);
        vecs[i].x = N'(xx); vecs[i].y = N'(yy); vecs[i].q = N'(q); vecs[i].r = N'(r);
        vecs[i].z = z[0];   vecs[i].o = o[0];   vecs[i].lat = lat;
    endtask

    // Reference: language-level truncating division plus the dbz/ovf rules.
    function automatic void model(input logic [N-1:0] xx, input logic [N-1:0] yy,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z, output logic o);
        int xi, yi;
        xi = $signed(xx);
        yi = $signed(yy);
        z = 1'b0; o = 1'b0;
        if (yi == 0) begin
            q = '1; r = xx; z = 1'b1;
        end else if (xi == -(1 << (N-1)) && yi == -1) begin
            q = xx; r = '0; o = 1'b1;
        end else begin
            q = N'(xi / yi); r = N'(xi % yi);
        end
    endfunction

    task automatic run_div(input logic [N-1:0] xx, input logic [N-1:0] yy, output int lat);
        @(negedge clk);
        x = xx; y = yy; start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int           lat, cnt;
        logic [N-1:0] eq, er;
        logic         ez, eo;

        setv(0,  100,    7,  14,   2, 0, 0, 9);
        setv(1, -100,    7, -14,  -2, 0, 0, 9);
        setv(2,  100,   -7, -14,   2, 0, 0, 9);
        setv(3, -100,   -7,  14,  -2, 0, 0, 9);
        setv(4, -128,   -1, -128,  0, 0, 1, 9);
        setv(5, -128,    1, -128,  0, 0, 0, 9);
        setv(6,  127, -128,   0, 127, 0, 0, 9);
        setv(7,    0,    5,   0,   0, 0, 0, 9);
        setv(8,    5,    0,  -1,   5, 1, 0, 1);
        setv(9,    9,    3,   3,   0, 0, 0, 9);

        rst = 1'b0; start = 1'b0; x = '0; y = '0;
        #12;
        chk("reset outputs", {busy, done, Q, R, dbz, ovf}, '0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].x, vecs[i].y, lat);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d Q", i), Q, vecs[i].q);
            chk($sformatf("vec%0d R", i), R, vecs[i].r);
            chk($sformatf("vec%0d dbz/ovf", i), {dbz, ovf}, {vecs[i].z, vecs[i].o});
            chk($sformatf("vec%0d busy at done", i), busy, 1'b0);
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        x = 8'd50; y = 8'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) begin x = 8'd1; y = 8'd1; start = 1'b1; end
        @(posedge clk);
        @(negedge clk) begin start = 1'b0; x = '0; y = '0; end
        lat = 4;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore latency", lat, 9);
        chk("ignore Q/R", {Q, R}, {8'd16, 8'd2});

        // asynchronous reset in the middle of a division
        @(negedge clk);
        x = 8'd77; y = 8'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async reset", {busy, done, Q, R}, '0);
        @(negedge clk) rst = 1'b1;
        run_div(8'd77, 8'd5, lat);
        chk("after reset latency", lat, 9);
        chk("after reset Q/R", {Q, R, dbz, ovf}, {8'd15, 8'd2, 2'b00});

        for (int i = 0; i < 100; i++) begin
            rx[i] = N'($urandom);
            ry[i] = N'($urandom);
            if (i % 10 == 3) ry[i] = '0;
            if (i % 25 == 7) begin rx[i] = 8'h80; ry[i] = 8'hFF; end
        end

        // start held high: each op is accepted on the edge after the previous done
        @(negedge clk);
        x = rx[0]; y = ry[0]; start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
            end while (!done && cnt < 40);
            model(rx[i], ry[i], eq, er, ez, eo);
            chk($sformatf("rand%0d x=%0h y=%0h", i, rx[i], ry[i]),
                {Q, R, dbz, ovf, busy, 8'(cnt)},
                {eq, er, ez, eo, 1'b0, 8'(ry[i] == '0 ? 2 : N + 2)});
            if (i < 99) begin x = rx[i+1]; y = ry[i+1]; end
            if (pass_cnt != chk_cnt) break;
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed integer divider. It is the inverse companion of the team's radix-2 Booth multiplier.
- Computes quotient Q = x / y and remainder R = x % y for DATA_WIDTH-bit two's-complement operands.
- Uses a radix-2 non-restoring shift/subtract datapath and produces one quotient bit per clock.
- Sits beside the multiplier in the arithmetic block and uses a start/done handshake.

Parameters:
- DATA_WIDTH, 8, width of dividend, divisor, quotient and remainder (valid range 4..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk).
- start  input  1  request a division; sampled on the rising clk edge.
- x  input  DATA_WIDTH  signed dividend; sampled when start is accepted.
- y  input  DATA_WIDTH  signed divisor; sampled when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when Q/R/flags are updated.
- Q  output  DATA_WIDTH  signed quotient.
- R  output  DATA_WIDTH  signed remainder.
- dbz  output  1  divide-by-zero flag for the current result.
- ovf  output  1  overflow flag for the current result (only case: -2^(DATA_WIDTH-1) / -1).

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, counter=0, busy=0, done=0, Q=0, R=0, dbz=0, ovf=0. Any partial result is discarded.
- States:
  - IDLE: counter=0.
  - CALC: counter runs DATA_WIDTH down to 1.
  - FIX: one cycle.
- Handshake:
  - start is accepted only when busy=0.
  - start while busy=1 is ignored and does not restart, queue or change operands.
  - start held high across done is accepted again on the first cycle busy=0, i.e. back-to-back operation is allowed.
- Accept edge E0: latch |x|, |y| and the operand signs. Then:
  - y==0: go to FIX directly, busy=1 for one cycle.
  - otherwise: go to CALC with counter=DATA_WIDTH, busy=1.
- CALC: each edge does one non-restoring step.
  - Partial remainder P (DATA_WIDTH+1 bits, signed) shifts left, bringing in the next dividend bit.
  - If P was non-negative, subtract |y|; otherwise add |y|.
  - The quotient bit is the inverted new sign of P.
  - counter decrements; at counter==1 the next state is FIX.
- FIX edge (E_{DATA_WIDTH+1}):
  - If P<0, add |y| back to P (remainder correction).
  - Apply signs: quotient is negative iff signs differ; remainder takes the dividend's sign.
  - Register Q, R, dbz and ovf, then return to IDLE. done=1 and busy=0 for exactly the next cycle.
- Latency: done is high DATA_WIDTH+1 cycles after the accept edge for y!=0, and 1 cycle after for y==0.
- Rounding: truncation toward zero, matching Verilog signed / and %. Invariant: x == Q*y + R, with |R| < |y|.
- Divide by zero: Q = all ones (-1), R = x, dbz=1, ovf=0.
- Overflow (x = -2^(N-1), y = -1): Q = -2^(N-1) (wrapped), R=0, ovf=1, dbz=0.
- |x| for x = -2^(N-1) is computed unsigned in DATA_WIDTH+1 bits, with no intermediate truncation.
- Outputs Q/R/dbz/ovf hold their last values until the next FIX edge. They do not change during CALC.
- Verification hooks:
  - counter is 0 exactly when state=IDLE.
  - busy==(state!=IDLE).
  - done never asserts while busy=1.

Test Plan:
- After reset release, start with x=100, y=7 -> done at accept+9 cycles (N=8), Q=14, R=2, dbz=0, ovf=0. Repeat with x=-100, y=7 -> Q=-14, R=-2; with x=100, y=-7 -> Q=-14, R=2; with x=-100, y=-7 -> Q=14, R=-2.
- Boundary cases:
  - x=-128, y=-1 -> Q=-128, R=0, ovf=1.
  - x=-128, y=1 -> Q=-128, R=0, ovf=0.
  - x=127, y=-128 -> Q=0, R=127.
  - x=0, y=5 -> Q=0, R=0.
- x=5, y=0 -> done one cycle after accept, Q=-1 (8'hFF), R=5, dbz=1; the next division (9/3 -> Q=3, R=0) clears dbz.
- Start x=50, y=3; pulse start with x=1, y=1 at accept+4 -> second request ignored, result Q=16, R=2. Then assert rst=0 at accept+3 of a new 77/5 division -> busy, done, Q and R are 0 immediately (asynchronously); after release, a fresh 77/5 gives Q=15, R=2.
- 100 random signed operand pairs with start held high (back-to-back; y==0 included) -> on every done, Q and R equal the Verilog signed / and % results (or the dbz/ovf rules). The bench stops with an error on the first mismatch.
